serial_adder_core: RTL and testbench
====================================

Name: serial_adder_core

Overview:
- Bit-serial N-bit adder that consumes the divided clock produced by the clock divider stage.
- At top level, the divider's output drives this block's CLK_IN.
- Parallel-loads two operands on START, then adds one bit per clock, LSB first, through a single full adder and carry flip-flop.
- Presents the parallel sum, carry-out and signed overflow with a one-cycle DONE pulse; also streams each sum bit as it is produced.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK_IN  input  1  block clock (divided clock from clock divider); all logic on rising edge
RST  input  1  synchronous, active-high reset, sampled on rising CLK_IN
START  input  1  request an addition; accepted only in IDLE
A  input  WIDTH  operand A, sampled on the accepting edge only
B  input  WIDTH  operand B, sampled on the accepting edge only
CIN  input  1  carry-in, sampled on the accepting edge only
BUSY  output  1  high while bits are being processed (SHIFT state)
DONE  output  1  one-cycle pulse: SUM/COUT/OVF are valid
SUM  output  WIDTH  registered result; held until the next result is written
COUT  output  1  final carry-out; held with SUM
OVF  output  1  signed overflow (carry into MSB XOR carry out); held with SUM
SUM_BIT  output  1  sum bit produced in the current SHIFT cycle
SUM_BIT_VLD  output  1  high when SUM_BIT is meaningful; equals BUSY

Behaviour:
- The clock is single and the reset is synchronous and active-high, as fixed above: CLK_IN is the only clock and RST is sampled on its rising edge.
- Reset values:
  - state = IDLE.
  - BUSY, DONE, SUM, COUT, OVF, SUM_BIT and SUM_BIT_VLD = 0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
- RST has priority over all other inputs in every state. Reset mid-operation aborts the addition; SUM/COUT/OVF clear; no DONE is issued.
- States: IDLE, SHIFT, DONE.
  - IDLE, START=1: load A and B into shift registers, carry <= CIN, counter <= 0, go to SHIFT.
  - IDLE, START=0: hold.
  - SHIFT, each edge:
    - s = a[0]^b[0]^c; c <= majority(a[0],b[0],c).
    - Shift s into the MSB of the result shift register (right shift). Shift a and b right by 1. counter += 1.
    - On the edge where counter == WIDTH-1: latch SUM <= final result; COUT <= carry out of the MSB; OVF <= carry into MSB XOR carry out; go to DONE.
  - DONE: DONE=1 for exactly one cycle, then go to IDLE unconditionally.
- START is ignored in SHIFT and DONE; it is neither queued nor latched. A/B/CIN changes after the accepting edge have no effect.
- SUM_BIT is combinational from the current shift-register LSBs and carry, qualified by SUM_BIT_VLD. The bit for weight i appears in SHIFT cycle i+1.
- Latency, with the START-accepting edge at the end of cycle 0:
  - BUSY high in cycles 1..WIDTH.
  - DONE high in cycle WIDTH+1.
  - Back in IDLE in cycle WIDTH+2, so the earliest next START is accepted at the end of cycle WIDTH+2.
  - Throughput is one addition per WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH with COUT as bit WIDTH. Wrap-around (e.g. all-ones + 1) yields SUM = 0, COUT = 1.
- SUM/COUT/OVF hold their last values through IDLE and through the following SHIFT; they update only on the edge that enters DONE.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), sampled with A/B on the accepting edge.
  - SUB=1: B is loaded inverted and CIN is ignored, with carry <= 1, giving A-B in two's complement. COUT=1 means no borrow. OVF is signed overflow of the subtraction.
  - SUB=0: identical to the base behaviour.
- Undefined: no SUB port; the block is an adder only; gate count is unchanged from the base.

Test Plan:
- Reset, then WIDTH=8, A=8'h0F, B=8'h01, CIN=0, START pulsed one cycle -> BUSY high for 8 cycles; DONE in cycle 9; SUM=8'h10, COUT=0, OVF=0; SUM_BIT sequence LSB-first 0,0,0,0,1,0,0,0.
- A=8'hFF, B=8'h01, CIN=0 -> SUM=8'h00, COUT=1, OVF=0. Repeat with A=8'hFF, B=8'h00, CIN=1 -> same result.
- A=8'h7F, B=8'h01 -> SUM=8'h80, COUT=0, OVF=1. A=8'h80, B=8'h80 -> SUM=8'h00, COUT=1, OVF=1.
- Start A=8'h12, B=8'h34. Assert START with A=8'hFF, B=8'hFF in SHIFT cycle 3 and again in the DONE cycle -> both ignored; SUM=8'h46. The next START in IDLE is accepted normally.
- Start A=8'hAA, B=8'h55; assert RST in SHIFT cycle 4 -> next cycle all outputs are 0 and state is IDLE; no DONE pulse. A following START with 8'h01+8'h02 gives SUM=8'h03.
- With SERIAL_ADDER_SUB_EN defined: A=8'h05, B=8'h07, SUB=1 -> SUM=8'hFE, COUT=0, OVF=0. A=8'h80, B=8'h01, SUB=1 -> SUM=8'h7F, COUT=1, OVF=1.

Source files
------------

// File: rtl/serial_adder_core.sv
// serial_adder_core
//   Bit-serial WIDTH-bit adder. Operands are parallel-loaded on an accepted
//   START. The block then adds one bit per clock, LSB first, using a single
//   full adder and a carry flop. It presents SUM/COUT/OVF together with a
//   one-cycle DONE pulse, and streams each sum bit as it is produced.
//
//   Clocking: CLK_IN is the divided clock from the clock divider stage.
//   Reset:    RST is synchronous and active-high, and has priority over all other inputs.
//
//   Ports:
//     CLK_IN       in   block clock; all logic on the rising edge
//     RST          in   synchronous active-high reset
//     START        in   request an addition; accepted only in IDLE
//     A, B         in   operands [WIDTH-1:0]; sampled on the accepting edge
//     CIN          in   carry-in; sampled on the accepting edge
//     SUB          in   (only with SERIAL_ADDER_SUB_EN) 1 selects A-B
//     BUSY         out  high in SHIFT
//     DONE         out  one-cycle pulse; SUM/COUT/OVF valid
//     SUM          out  registered result, held until the next result
//     COUT         out  final carry-out
//     OVF          out  signed overflow (carry into MSB xor carry out)
//     SUM_BIT      out  sum bit produced in the current SHIFT cycle
//     SUM_BIT_VLD  out  equals BUSY
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN (adds the SUB port).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for START, last result held
//   SHIFT   | one bit per cycle through the full adder
//   DONE    | result just latched, DONE pulse for one cycle

module serial_adder_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             SUM_BIT,
    output logic             SUM_BIT_VLD
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: A + ~B + 1. CIN is ignored in this mode.
    assign b_load   = SUB ? ~B : B;
    assign cin_load = SUB ? 1'b1 : CIN;
`else
    assign b_load   = B;
    assign cin_load = CIN;
`endif

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = b_load;
                    carry_d = cin_load;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    // carry_q is the carry into the MSB on this last step
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign BUSY        = (state_q == ST_SHIFT);
    assign DONE        = (state_q == ST_DONE);
    assign SUM         = sum_q;
    assign COUT        = cout_q;
    assign OVF         = ovf_q;
    assign SUM_BIT_VLD = BUSY;
    assign SUM_BIT     = fa_sum & BUSY;

endmodule

// File: tb/tb_serial_adder_core.sv
module tb_serial_adder_core;

    localparam int W = 8;

    logic         CLK_IN = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
`ifdef SERIAL_ADDER_SUB_EN
    logic         SUB;
`endif
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;
    logic         SUM_BIT;
    logic         SUM_BIT_VLD;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf  = 1'b0;

    serial_adder_core #(.WIDTH(W), .CNT_W(5)) dut (
        .CLK_IN      (CLK_IN),
        .RST         (RST),
        .START       (START),
        .A           (A),
        .B           (B),
        .CIN         (CIN),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB         (SUB),
`endif
        .BUSY        (BUSY),
        .DONE        (DONE),
        .SUM         (SUM),
        .COUT        (COUT),
        .OVF         (OVF),
        .SUM_BIT     (SUM_BIT),
        .SUM_BIT_VLD (SUM_BIT_VLD)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    // One full operation, starting from an IDLE cycle. inj_shift > 0 pulses
    // START (with junk operands) in that SHIFT cycle; inj_done pulses it in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int inj_shift, input bit inj_done);
        longint       r;
        int           sa, sb, sres;
        logic [W-1:0] exp_sum;
        logic         exp_cout, exp_ovf;

        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r    = longint'(a) + longint'((~b) & {W{1'b1}}) + 1;
            sres = sa - sb;
        end else begin
            r    = longint'(a) + longint'(b) + longint'(cin);
            sres = sa + sb + int'(cin);
        end
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        exp_ovf  = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));

        A = a; B = b; CIN = cin;
`ifdef SERIAL_ADDER_SUB_EN
        SUB = sub;
`endif
        START = 1'b1;
        tick();
        START = 1'b0;
        A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        SUB = 1'($urandom);
`endif
        for (int i = 1; i <= W; i++) begin
            check_val("busy", BUSY, 1);
            check_val("done_in_shift", DONE, 0);
            check_val("sum_bit_vld", SUM_BIT_VLD, 1);
            check_val($sformatf("sum_bit[%0d]", i - 1), SUM_BIT, exp_sum[i-1]);
            check_val("sum_held", {prev_ovf, prev_cout, SUM}, {prev_ovf, prev_cout, prev_sum});
            if (i == inj_shift) begin
                START = 1'b1; A = '1; B = '1;
            end else begin
                START = 1'b0;
            end
            tick();
        end
        START = 1'b0;
        check_val("done", DONE, 1);
        check_val("busy_in_done", BUSY, 0);
        check_val("sum", SUM, exp_sum);
        check_val("cout", COUT, exp_cout);
        check_val("ovf", OVF, exp_ovf);
        if (inj_done) begin
            START = 1'b1; A = '1; B = '1;
        end
        tick();
        START = 1'b0;
        check_val("idle_done", DONE, 0);
        check_val("idle_busy", BUSY, 0);
        if (inj_done || inj_shift > 0) begin
            tick();
            check_val("start_ignored", BUSY, 0);
            check_val("sum_after_ignore", SUM, exp_sum);
        end
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
        prev_ovf  = exp_ovf;
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        SUB = 1'b0;
`endif
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check_val("rst_outputs", {BUSY, DONE, SUM, COUT, OVF, SUM_BIT, SUM_BIT_VLD}, '0);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 1'b1);
        run_op(8'h21, 8'h43, 1'b1, 1'b0, 0, 1'b0);

        // Reset in SHIFT cycle 4 aborts; no DONE afterwards.
        A = 8'hAA; B = 8'h55; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        check_val("busy_before_rst", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_val("abort_outputs", {BUSY, DONE, SUM, COUT, OVF, SUM_BIT, SUM_BIT_VLD}, '0);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            check_val("no_done_after_abort", {DONE, BUSY}, 0);
        end
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), s, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
